// File: rtl/player_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_bullet_ctrl
// Description : Owns the player's single bullet.
//               - Captures fire requests and spawns the bullet centred above
//                 the ship on the next frame start (fsync).
//               - Moves the bullet up BULLET_SPEED pixels per frame.
//               - Retires the bullet on alien_hit or when it leaves the top
//                 of the screen.
//               - Blocks new shots for COOLDOWN_FRAMES frames after
//                 retirement.
// Ports       : pixel_clk, rst (sync, active-high), fsync (frame pulse),
//               fire_btn (debounced level), ship_lhpos/ship_rhpos/ship_tvpos
//               (signed ship box), alien_hit (from collision_controller),
//               bullet_active, bullet_left/right/top/bottom (inclusive box),
//               shots_fired (wrapping spawn counter).
// Options     : `define AUTOFIRE_EN makes a held fire_btn count as a pending
//               shot while idle, so the bullet re-fires after each cooldown.
// Revision    : 1.0 - initial release
// ============================================================================
module player_bullet_ctrl #(
    parameter int BULLET_W        = 4,
    parameter int BULLET_H        = 8,
    parameter int BULLET_SPEED    = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               fire_btn,
    input  logic signed [11:0] ship_lhpos,
    input  logic signed [11:0] ship_rhpos,
    input  logic signed [11:0] ship_tvpos,
    input  logic               alien_hit,
    output logic               bullet_active,
    output logic signed [11:0] bullet_left,
    output logic signed [11:0] bullet_right,
    output logic signed [11:0] bullet_top,
    output logic signed [11:0] bullet_bottom,
    output logic [15:0]        shots_fired
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam int c_cnt_w = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_cool_load = c_cnt_w'(COOLDOWN_FRAMES);
    localparam logic signed [12:0] c_half_w    = 13'(BULLET_W / 2);
    localparam logic signed [11:0] c_width_m1  = 12'(BULLET_W - 1);
    localparam logic signed [11:0] c_height    = 12'(BULLET_H);
    localparam logic signed [11:0] c_height_m1 = 12'(BULLET_H - 1);
    localparam logic signed [11:0] c_speed     = 12'(BULLET_SPEED);

    state_t               state_q, state_d;
    logic                 fire_btn_q;
    logic                 fire_pending_q, fire_pending_d;
    logic [c_cnt_w-1:0]   cool_cnt_q, cool_cnt_d;
    logic                 bullet_active_q, bullet_active_d;
    logic signed [11:0]   bullet_left_q, bullet_left_d;
    logic signed [11:0]   bullet_right_q, bullet_right_d;
    logic signed [11:0]   bullet_top_q, bullet_top_d;
    logic signed [11:0]   bullet_bottom_q, bullet_bottom_d;
    logic [15:0]          shots_fired_q, shots_fired_d;

    logic                 fire_rise;
    logic                 fire_req;
    logic signed [12:0]   centre_sum;
    logic signed [12:0]   centre_x;
    logic signed [11:0]   spawn_left;
    logic signed [11:0]   spawn_top;
    logic signed [11:0]   moved_top;
    logic signed [11:0]   moved_bottom;

    // Ship edges are summed at 13 bits so the midpoint never overflows; the
    // arithmetic shift rounds toward minus infinity for negative centres.
    assign centre_sum   = {ship_lhpos[11], ship_lhpos} + {ship_rhpos[11], ship_rhpos};
    assign centre_x     = centre_sum >>> 1;
    assign spawn_left   = 12'(centre_x - c_half_w);
    assign spawn_top    = ship_tvpos - c_height;
    assign moved_top    = bullet_top_q - c_speed;
    assign moved_bottom = bullet_bottom_q - c_speed;

    assign fire_rise = fire_btn & ~fire_btn_q;
`ifdef AUTOFIRE_EN
    assign fire_req  = fire_pending_q | fire_rise | fire_btn;
`else
    assign fire_req  = fire_pending_q | fire_rise;
`endif

    always_comb begin
        state_d         = state_q;
        fire_pending_d  = fire_pending_q;
        cool_cnt_d      = cool_cnt_q;
        bullet_active_d = bullet_active_q;
        bullet_left_d   = bullet_left_q;
        bullet_right_d  = bullet_right_q;
        bullet_top_d    = bullet_top_q;
        bullet_bottom_d = bullet_bottom_q;
        shots_fired_d   = shots_fired_q;

        case (state_q)
            ST_IDLE: begin
                if (fsync && fire_req) begin
                    bullet_left_d   = spawn_left;
                    bullet_right_d  = spawn_left + c_width_m1;
                    bullet_top_d    = spawn_top;
                    bullet_bottom_d = spawn_top + c_height_m1;
                    bullet_active_d = 1'b1;
                    shots_fired_d   = shots_fired_q + 16'd1;
                    fire_pending_d  = 1'b0;
                    state_d         = ST_FLYING;
                end else if (fire_rise) begin
                    fire_pending_d  = 1'b1;
                end
            end

            ST_FLYING: begin
                // A hit retires the bullet at once and suppresses any move
                // scheduled for the same cycle.
                if (alien_hit) begin
                    bullet_active_d = 1'b0;
                    cool_cnt_d      = c_cool_load;
                    state_d         = ST_COOLDOWN;
                end else if (fsync) begin
                    bullet_top_d    = moved_top;
                    bullet_bottom_d = moved_bottom;
                    if (moved_bottom[11]) begin
                        bullet_active_d = 1'b0;
                        cool_cnt_d      = c_cool_load;
                        state_d         = ST_COOLDOWN;
                    end
                end
            end

            ST_COOLDOWN: begin
                if (fsync) begin
                    if (cool_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cool_cnt_d = cool_cnt_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            fire_btn_q      <= 1'b0;
            fire_pending_q  <= 1'b0;
            cool_cnt_q      <= '0;
            bullet_active_q <= 1'b0;
            bullet_left_q   <= '0;
            bullet_right_q  <= '0;
            bullet_top_q    <= '0;
            bullet_bottom_q <= '0;
            shots_fired_q   <= '0;
        end else begin
            state_q         <= state_d;
            fire_btn_q      <= fire_btn;
            fire_pending_q  <= fire_pending_d;
            cool_cnt_q      <= cool_cnt_d;
            bullet_active_q <= bullet_active_d;
            bullet_left_q   <= bullet_left_d;
            bullet_right_q  <= bullet_right_d;
            bullet_top_q    <= bullet_top_d;
            bullet_bottom_q <= bullet_bottom_d;
            shots_fired_q   <= shots_fired_d;
        end
    end

    assign bullet_active = bullet_active_q;
    assign bullet_left   = bullet_left_q;
    assign bullet_right  = bullet_right_q;
    assign bullet_top    = bullet_top_q;
    assign bullet_bottom = bullet_bottom_q;
    assign shots_fired   = shots_fired_q;

endmodule
`default_nettype wire

// File: doc/player_bullet_ctrl.md
Name: player_bullet_ctrl

Overview:
Owns the player's single bullet. Detects fire requests, spawns the bullet centred above the ship, and advances it upward once per frame on fsync. Retires the bullet on an alien hit or when it leaves the top of the screen, then enforces a frame-count cooldown. Sits directly upstream of collision_controller: it drives bullet_active and the bullet box, and consumes alien_hit.

Parameters:
BULLET_W, 4, bullet width in pixels (even, >=2)
BULLET_H, 8, bullet height in pixels (>=1)
BULLET_SPEED, 4, pixels moved upward per frame (>=1)
COOLDOWN_FRAMES, 2, fsync pulses after retirement before a new shot is accepted (0 = none)

Ports:
pixel_clk  input  1  pixel clock
rst  input  1  synchronous active-high reset
fsync  input  1  one-cycle frame-start pulse
fire_btn  input  1  fire button level, already synchronised and debounced
ship_lhpos  input  12 signed  ship left edge
ship_rhpos  input  12 signed  ship right edge
ship_tvpos  input  12 signed  ship top edge
alien_hit  input  1  hit flag from collision_controller
bullet_active  output  1  bullet is live
bullet_left / bullet_right / bullet_top / bullet_bottom  output  12 signed each  bullet box, inclusive
shots_fired  output  16  count of spawned bullets; wraps

Behaviour:
- Reset is rst, synchronous, active-high; clock is pixel_clk. Any cycle with rst=1 clears every output to 0, sets state=IDLE and clears fire_pending, cooldown counter and the fire_btn history register. This applies mid-flight too.
- Edge detect: fire_rise = fire_btn & ~fire_btn_q, where fire_btn_q is the value registered the previous cycle.
- fire_pending is set by fire_rise only while state=IDLE. It is cleared on spawn. Rises in FLYING or COOLDOWN are discarded.
- IDLE:
  - On fsync with fire_pending (or with fire_rise in that same cycle), spawn.
  - Spawn values: centre = (ship_lhpos + ship_rhpos) computed at 13 bits, then arithmetic shift right 1.
  - bullet_left = centre - BULLET_W/2; bullet_right = bullet_left + BULLET_W - 1.
  - bullet_top = ship_tvpos - BULLET_H; bullet_bottom = bullet_top + BULLET_H - 1.
  - bullet_active <= 1; shots_fired += 1; state -> FLYING. No movement occurs in the spawn frame.
- FLYING, evaluated in priority order:
  1. alien_hit=1 in any cycle: bullet_active <= 0 on the next edge and state -> COOLDOWN. This is immediate, so collision_controller never sees the same bullet twice. Hit beats a simultaneous fsync, and no movement happens.
  2. fsync: bullet_top and bullet_bottom each decrease by BULLET_SPEED. If the new bullet_bottom < 0, bullet_active <= 0 and state -> COOLDOWN.
- Box outputs change only at spawn, at fsync movement, and at reset. They hold their last values after retirement (don't-care while bullet_active=0).
- COOLDOWN:
  - On entry, load counter = COOLDOWN_FRAMES.
  - Each fsync: if counter==0, go to IDLE; else decrement.
  - With COOLDOWN_FRAMES=0, the first fsync returns to IDLE.
  - alien_hit is ignored in this state.
- Arithmetic is 12-bit signed two's complement. Positions may go negative; wrap on overflow is not guarded (the screen is assumed within ±2047).
- Latency: spawn appears on the cycle after the qualifying fsync. Retirement on hit lands the cycle after alien_hit is seen.

Optional Feature:
AUTOFIRE_EN
- Defined: in IDLE, fire_btn held high (level) counts as a pending fire, so a held button re-fires at the first fsync after cooldown.
- Undefined: only a fresh rising edge captured in IDLE fires.

Test Plan:
- Spawn: ship lh=100, rh=131, tv=440; pulse fire then fsync -> next cycle active=1, box L113 R116 T432 B439, shots_fired=1.
- Movement: after spawn, 3 further fsyncs -> top=420, bottom=427; left/right unchanged; no change between fsyncs.
- Hit: alien_hit=1 two cycles after fsync while flying -> active=0 next cycle. Fire pressed during cooldown is ignored. After 3 fsyncs (COOLDOWN_FRAMES=2) the state is IDLE, and a new fire spawns.
- Exit top: spawn at tv=16 (top=8, bottom=15); fsync #1 -> bottom=11; fsync #4 -> bottom=-1, active=0.
- Simultaneous: alien_hit and fsync in the same cycle -> active=0, top unchanged. Also assert rst mid-flight -> all outputs 0 and shots_fired=0 next cycle.
- AUTOFIRE_EN: hold fire_btn=1 for 20 frames with no hits. With the macro defined, shots respawn each time after off-screen plus cooldown; without it, shots_fired stays 1.
